// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two clients.
// Define RAM_ARBITER_INIT_EN to build the post-reset RAM clear sequence (Busy high meanwhile).
module ram_arbiter #(
  parameter int N = 16,
  parameter int M = 6
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Req0,
  input  logic         Req1,
  input  logic         We0,
  input  logic         We1,
  input  logic [M-1:0] A0,
  input  logic [M-1:0] A1,
  input  logic [N-1:0] D0,
  input  logic [N-1:0] D1,
  output logic         Gnt0,
  output logic         Gnt1,
  output logic         Rvalid0,
  output logic         Rvalid1,
  output logic [N-1:0] Rdata,
  output logic         Busy,
  output logic         RamWE,
  output logic [M-1:0] RamA,
  output logic [N-1:0] RamD,
  input  logic [N-1:0] RamQ
);

  logic         run_s;
  logic         init_s;
  logic [M-1:0] clr_addr_s;
  logic         last_r;
  logic         rvalid0_r;
  logic         rvalid1_r;
  logic         gnt0_s;
  logic         gnt1_s;
  logic         ram_we_s;
  logic [M-1:0] ram_a_s;
  logic [N-1:0] ram_d_s;

`ifdef RAM_ARBITER_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t       state_r;
  state_t       state_s;
  logic [M:0]   cnt_r;
  logic [M:0]   cnt_s;

  // State register and clear counter
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_INIT;
      cnt_r   <= {(M+1){1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Clear sequencing: leave INIT once the last address has been written
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_s = cnt_r + {{M{1'b0}}, 1'b1};
        if (cnt_r[M-1:0] == {M{1'b1}}) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_INIT;
    endcase
  end

  assign init_s     = (state_r == ST_INIT);
  assign run_s      = (state_r == ST_RUN);
  assign clr_addr_s = cnt_r[M-1:0];
  assign Busy       = init_s;
`else
  assign init_s     = 1'b0;
  assign run_s      = 1'b1;
  assign clr_addr_s = {M{1'b0}};
  assign Busy       = 1'b0;
`endif

  // Grant selection; Last names the port that must yield under contention
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (Reset && run_s) begin
      if (Req0 && Req1) begin
        if (last_r) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else if (Req0) begin
        gnt0_s = 1'b1;
      end else if (Req1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
    end
  end

  // RAM port mux: clear writes, then granted port, otherwise quiet zeros
  always_comb begin
    ram_we_s = 1'b0;
    ram_a_s  = {M{1'b0}};
    ram_d_s  = {N{1'b0}};
    if (init_s) begin
      ram_we_s = Reset;
      ram_a_s  = clr_addr_s;
    end else if (gnt0_s) begin
      ram_we_s = We0;
      ram_a_s  = A0;
      ram_d_s  = D0;
    end else if (gnt1_s) begin
      ram_we_s = We1;
      ram_a_s  = A1;
      ram_d_s  = D1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Priority pointer and read-valid strobes
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      last_r    <= 1'b1;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      if (gnt0_s) begin
        last_r <= 1'b0;
      end else if (gnt1_s) begin
        last_r <= 1'b1;
      end else begin
        last_r <= last_r;
      end
      rvalid0_r <= gnt0_s & ~We0;
      rvalid1_r <= gnt1_s & ~We1;
    end
  end

  assign Gnt0    = gnt0_s;
  assign Gnt1    = gnt1_s;
  assign RamWE   = ram_we_s;
  assign RamA    = ram_a_s;
  assign RamD    = ram_d_s;
  assign Rvalid0 = rvalid0_r;
  assign Rvalid1 = rvalid1_r;
  assign Rdata   = RamQ;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, reference model checked every cycle, directed scenarios.
// Honours RAM_ARBITER_INIT_EN for the clear-sequence expectations.
module tb_ram_arbiter;
  localparam int N = 16;
  localparam int M = 6;
  localparam int DEPTH = 64;
`ifdef RAM_ARBITER_INIT_EN
  localparam int INIT_CYC = 64;
`else
  localparam int INIT_CYC = 0;
`endif
  localparam logic BUSY_RST = (INIT_CYC > 0);

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
  logic [M-1:0] A0 = '0, A1 = '0;
  logic [N-1:0] D0 = '0, D1 = '0;
  logic         Gnt0, Gnt1, Rvalid0, Rvalid1, Busy, RamWE;
  logic [N-1:0] Rdata, RamD, RamQ;
  logic [M-1:0] RamA;
  logic [N-1:0] ram_mem [DEPTH];

  int n_pass = 0;
  int n_total = 0;

  ram_arbiter #(.N(N), .M(M)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .A0(A0), .A1(A1), .D0(D0), .D1(D1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Rvalid0(Rvalid0), .Rvalid1(Rvalid1),
    .Rdata(Rdata), .Busy(Busy), .RamWE(RamWE), .RamA(RamA), .RamD(RamD), .RamQ(RamQ)
  );

  always #5 Clock = ~Clock;

  // Single-port synchronous RAM, write-through, one-cycle read latency
  always @(posedge Clock) begin
    if (RamWE) ram_mem[RamA] <= RamD;
    RamQ <= RamWE ? RamD : ram_mem[RamA];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: round-robin by "who won last", shadow memory for read data
  logic [N-1:0] sh_mem [DEPTH];
  bit           sh_known [DEPTH];
  initial begin : compare
    int m_last, g, init_left, ca;
    bit exp_rv0, exp_rv1, exp_known, we;
    logic [N-1:0] exp_rdata, d;
    logic [M-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin sh_mem[i] = '0; sh_known[i] = 1'b0; end
    m_last = 1; exp_rv0 = 0; exp_rv1 = 0; exp_known = 0; exp_rdata = '0; init_left = INIT_CYC;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        chk("m_rst_gnt0", Gnt0, 0); chk("m_rst_gnt1", Gnt1, 0);
        chk("m_rst_we", RamWE, 0);
        chk("m_rst_rv0", Rvalid0, 0); chk("m_rst_rv1", Rvalid1, 0);
        chk("m_rst_busy", Busy, BUSY_RST);
        m_last = 1; exp_rv0 = 0; exp_rv1 = 0; exp_known = 0; init_left = INIT_CYC;
      end else begin
        chk("m_rv0", Rvalid0, exp_rv0); chk("m_rv1", Rvalid1, exp_rv1);
        if ((exp_rv0 || exp_rv1) && exp_known) chk("m_rdata", Rdata, exp_rdata);
        exp_rv0 = 0; exp_rv1 = 0; exp_known = 0;
        if (init_left > 0) begin
          ca = DEPTH - init_left;
          chk("m_init_busy", Busy, 1);
          chk("m_init_gnt0", Gnt0, 0); chk("m_init_gnt1", Gnt1, 0);
          chk("m_init_we", RamWE, 1); chk("m_init_a", RamA, ca); chk("m_init_d", RamD, 0);
          sh_mem[ca] = '0; sh_known[ca] = 1'b1;
          init_left--;
        end else begin
          chk("m_busy", Busy, 0);
          g = -1;
          if (Req0 && Req1) g = (m_last == 0) ? 1 : 0;
          else if (Req0) g = 0;
          else if (Req1) g = 1;
          chk("m_gnt0", Gnt0, (g == 0)); chk("m_gnt1", Gnt1, (g == 1));
          if (g >= 0) begin
            we = (g == 0) ? We0 : We1;
            a  = (g == 0) ? A0 : A1;
            d  = (g == 0) ? D0 : D1;
            chk("m_ram_we", RamWE, we); chk("m_ram_a", RamA, a);
            if (we) begin
              chk("m_ram_d", RamD, d);
              sh_mem[a] = d; sh_known[a] = 1'b1;
            end else begin
              exp_rdata = sh_mem[a]; exp_known = sh_known[a];
              if (g == 0) exp_rv0 = 1; else exp_rv1 = 1;
            end
            m_last = g;
          end else begin
            chk("m_idle_we", RamWE, 0); chk("m_idle_a", RamA, 0); chk("m_idle_d", RamD, 0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic wait_grant(output int cycles);
    cycles = 0;
    @(negedge Clock);
    while (!(Gnt0 || Gnt1) && cycles < 200) begin
      @(negedge Clock);
      cycles++;
    end
  endtask

  initial begin : driver
    int cyc;
    int exp_ord [6];
    exp_ord = '{0, 1, 0, 1, 0, 1};
    repeat (3) begin
      @(negedge Clock);
      chk("rst_gnt0", Gnt0, 0); chk("rst_rv0", Rvalid0, 0); chk("rst_busy", Busy, BUSY_RST);
    end
    step();
    Reset = 1'b1; Req0 = 1'b1; We0 = 1'b0; A0 = 6'd0;
    wait_grant(cyc);
    chk("first_grant_cycle", cyc, INIT_CYC); chk("first_grant_port0", Gnt0, 1);
    step();
    Req0 = 1'b0;
    @(negedge Clock);
    chk("first_read_rv0", Rvalid0, 1);
`ifdef RAM_ARBITER_INIT_EN
    chk("cleared_rdata", Rdata, 16'h0000);
`endif
    step();
    // Preload: addr 5, 1, 2 via port 0
    Req0 = 1'b1; We0 = 1'b1; A0 = 6'd5; D0 = 16'h1234;
    step();
    A0 = 6'd1; D0 = 16'h0101;
    step();
    A0 = 6'd2; D0 = 16'h0202;
    step();
    // Single read via port 1
    Req0 = 1'b0; We0 = 1'b0; Req1 = 1'b1; We1 = 1'b0; A1 = 6'd5;
    @(negedge Clock);
    chk("single_gnt1", Gnt1, 1);
    step();
    Req1 = 1'b0;
    @(negedge Clock);
    chk("single_rv1", Rvalid1, 1); chk("single_rv0", Rvalid0, 0); chk("single_rdata", Rdata, 16'h1234);
    step();
    // Contention: both read for 6 cycles
    Req0 = 1'b1; We0 = 1'b0; A0 = 6'd1; Req1 = 1'b1; We1 = 1'b0; A1 = 6'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      chk("cont_gnt0", Gnt0, (exp_ord[k] == 0)); chk("cont_gnt1", Gnt1, (exp_ord[k] == 1));
      chk("cont_onehot", (Gnt0 && Gnt1), 0);
      if (k > 0) begin
        chk("cont_rv0", Rvalid0, (exp_ord[k-1] == 0));
        chk("cont_rdata", Rdata, (exp_ord[k-1] == 0) ? 16'h0101 : 16'h0202);
      end
      step();
    end
    Req0 = 1'b0; Req1 = 1'b0;
    @(negedge Clock);
    chk("cont_last_rv1", Rvalid1, 1); chk("cont_last_rdata", Rdata, 16'h0202);
    step();
    // Write then read of address 63 via port 0
    Req0 = 1'b1; We0 = 1'b1; A0 = 6'd63; D0 = 16'hBEEF;
    step();
    We0 = 1'b0;
    step();
    Req0 = 1'b0;
    @(negedge Clock);
    chk("wtr_rv0", Rvalid0, 1); chk("wtr_rdata", Rdata, 16'hBEEF);
    step();
    // Idle for 4 cycles; Last (port 0) must survive
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      chk("idle_we", RamWE, 0); chk("idle_a", RamA, 0);
      chk("idle_rv0", Rvalid0, 0); chk("idle_rv1", Rvalid1, 0);
      step();
    end
    Req0 = 1'b1; Req1 = 1'b1; We0 = 1'b0; We1 = 1'b0; A0 = 6'd1; A1 = 6'd5;
    @(negedge Clock);
    chk("idle_last_gnt1", Gnt1, 1); chk("idle_last_gnt0", Gnt0, 0);
    step();
    Req0 = 1'b0;
    @(negedge Clock);
    chk("idle_req1_gnt1", Gnt1, 1);
    step();
    // Reset during a granted read
    Req1 = 1'b0; Req0 = 1'b1; A0 = 6'd5;
    @(negedge Clock);
    chk("rmid_gnt0", Gnt0, 1);
    #2 Reset = 1'b0;
    #1 chk("rmid_async_gnt0", Gnt0, 0);
    step();
    chk("rmid_rv0", Rvalid0, 0); chk("rmid_rv1", Rvalid1, 0);
    step();
    Reset = 1'b1; Req1 = 1'b1;
    wait_grant(cyc);
    chk("rmid_grant_cycle", cyc, INIT_CYC);
    chk("rmid_gnt0_first", Gnt0, 1); chk("rmid_gnt1_first", Gnt1, 0);
    step();
    @(negedge Clock);
    chk("rmid_second_gnt1", Gnt1, 1);
    step();
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares one single-port synchronous RAM (write-through read port, one-cycle read latency) between two requesters. It sits between the RAM instance and its two clients. It muxes address, data and write-enable onto the RAM port each cycle and tags returned read data with a per-port valid strobe. Optionally, after reset it sequences a clear of the whole RAM before granting any access.

## Interface
- N, 16, data width; must match the RAM.
- M, 6, address width; RAM depth is 2**M.
- Clock  in  1  single clock; everything is rising-edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- Req0 / Req1  in  1  access request, held by the client until granted.
- We0 / We1  in  1  1 = write, 0 = read; qualified by Req.
- A0 / A1  in  M  address.
- D0 / D1  in  N  write data.
- Gnt0 / Gnt1  out  1  combinational grant; the access executes at the next rising edge.
- Rvalid0 / Rvalid1  out  1  registered; Rdata holds this port's read result this cycle.
- Rdata  out  N  shared read data, wired directly from RamQ.
- Busy  out  1  high while the clear sequence runs.
- RamWE  out  1  write enable to the RAM.
- RamA  out  M  address to the RAM.
- RamD  out  N  write data to the RAM.
- RamQ  in  N  read data from the RAM.

## Operation
- States:
  - INIT: clear sequence; exists only with the macro.
  - RUN: normal arbitration.
- Reset entry: with the macro, reset enters INIT; without it, reset enters RUN.
- Reset values:
  - Rvalid0 = Rvalid1 = 0.
  - Priority pointer Last = 1, so port 0 wins first.
  - Clear counter = 0.
  - Busy = 1 with the macro, 0 without.
  - Gnt0 = Gnt1 = 0 and RamWE = 0 while Reset is low.
- RUN arbitration, evaluated combinationally each cycle:
  - Only Req0 high: grant port 0.
  - Only Req1 high: grant port 1.
  - Both high: grant the port that is not Last.
  - Neither high: no grant. RamWE = 0, RamA = 0, RamD = 0.
- Last updates at the clock edge to the index of the granted port. It holds when there is no grant.
- Granted port i drives RamWE = Wei, RamA = Ai, RamD = Di.
- Rvalid_i is set at the edge for a granted read (Wei = 0), otherwise cleared. Rvalid is never set for a write.
- At most one Gnt and at most one Rvalid are high in any cycle.
- A client that keeps Req high after a grant issues back-to-back accesses. Under contention, grants strictly alternate.
- Write then read of the same address in consecutive cycles returns the new data, since the RAM write commits at the same edge.

## Timing
- Grant: zero-cycle combinational path from Req.
- Read latency: request granted in cycle t; Rvalid and Rdata valid in cycle t+1.
- Write: committed at the end of the grant cycle. No completion strobe.
- Throughput: one access per cycle total.
- INIT (macro only):
  - Every cycle drives RamWE = 1, RamA = counter, RamD = 0; counter increments.
  - After address 2**M-1 is written: state becomes RUN and Busy drops.
  - First grant possible in cycle 2**M after reset release.
  - Gnt0 = Gnt1 = 0 throughout INIT; requests are held, not dropped.
- Counter is M+1 bits. The terminal test is on the M-bit address equal to all ones, so no wrap occurs.
- Reset asserted mid-operation:
  - Outputs return to their reset values immediately.
  - An in-flight Rvalid is lost.
  - A partial INIT restarts from address 0.

## Configuration
- RAM_ARBITER_INIT_EN defined:
  - INIT state and clear counter are built.
  - Busy = 1 for exactly 2**M cycles after reset release.
- RAM_ARBITER_INIT_EN undefined:
  - No counter is built.
  - Busy is tied 0.
  - Grants are possible in the first cycle after reset release.
  - RAM contents are left as loaded.

## Test plan
- Single read: write 16'h1234 to address 5 via port 0, then read address 5 via port 1 -> Gnt1 in the request cycle; next cycle Rvalid1 = 1, Rvalid0 = 0, Rdata = 16'h1234.
- Contention: both ports hold Req for 6 cycles, reading addresses 1 and 2 -> grant order 0,1,0,1,0,1; Rvalid alternates one cycle later; never both Gnt high.
- Write-then-read: port 0 writes 16'hBEEF to address 63 in cycle t, port 0 reads address 63 in cycle t+1 -> Rdata = 16'hBEEF with Rvalid0 in cycle t+2.
- Idle: no requests for 4 cycles -> RamWE = 0, RamA = 0, Rvalid0 = Rvalid1 = 0, Last unchanged; the next Req1 alone is granted immediately.
- Reset mid-operation: Reset low during a granted read -> Rvalid0 = Rvalid1 = 0 next cycle; after release, a simultaneous request from both ports grants port 0 first.
- Clear (with RAM_ARBITER_INIT_EN, M = 6): after release, Busy = 1 for exactly 64 cycles while RamA steps 0..63 with RamD = 0; Req0 held during that time is granted in cycle 64; reads of any address then return 0.
